// File: rtl/id_ex_pipeline_register.sv
// Decode/Execute boundary register with load-use hazard detection, one-cycle
// bubble insertion, memory-busy freeze, branch flush and a saturating bubble counter.
module id_ex_pipeline_register #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d_valid,
  input  logic [REG_W-1:0]   d_rsrc,
  input  logic [REG_W-1:0]   d_rdest,
  input  logic               d_uses_rsrc,
  input  logic               d_uses_rdest,
  input  logic [DATA_W-1:0]  d_read_data1,
  input  logic [DATA_W-1:0]  d_read_data2,
  input  logic [DATA_W-1:0]  d_imm,
  input  logic [ALUOP_W-1:0] d_alu_op,
  input  logic               d_reg_write,
  input  logic               d_mem_read,
  input  logic               d_mem_write,
  input  logic               d_in_port_select,
  input  logic               mem_busy,
  input  logic               flush,
  output logic               e_valid,
  output logic [REG_W-1:0]   e_rsrc,
  output logic [REG_W-1:0]   e_rdest,
  output logic [DATA_W-1:0]  e_read_data1,
  output logic [DATA_W-1:0]  e_read_data2,
  output logic [DATA_W-1:0]  e_imm,
  output logic [ALUOP_W-1:0] e_alu_op,
  output logic               e_reg_write,
  output logic               e_mem_read,
  output logic               e_mem_write,
  output logic               e_in_port_select,
  output logic               stall_fd,
  output logic [CNT_W-1:0]   bubble_count
);

  typedef struct packed {
    logic               valid;
    logic [REG_W-1:0]   rsrc;
    logic [REG_W-1:0]   rdest;
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [DATA_W-1:0]  imm;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               in_port_select;
  } ex_payload_t;

  typedef enum logic {ST_RUN, ST_BUBBLE} state_t;
  typedef enum logic [1:0] {ACT_LOAD, ACT_HOLD, ACT_CLEAR, ACT_BUBBLE} action_t;

  state_t      state, state_nxt;
  action_t     act;
  ex_payload_t ex_q, d_pl;
  logic [CNT_W-1:0] cnt_q;
  logic        haz;

  // Load in EX whose destination is read by the instruction in decode
  assign haz = ex_q.valid & ex_q.mem_read & d_valid &
               ((d_uses_rsrc  & (d_rsrc  == ex_q.rdest)) |
                (d_uses_rdest & (d_rdest == ex_q.rdest)));

  always_comb begin
    d_pl                = '0;
    d_pl.valid          = d_valid;
    d_pl.rsrc           = d_rsrc;
    d_pl.rdest          = d_rdest;
    d_pl.read_data1     = d_read_data1;
    d_pl.read_data2     = d_read_data2;
    d_pl.imm            = d_imm;
    d_pl.alu_op         = d_alu_op;
    d_pl.reg_write      = d_reg_write      & d_valid;
    d_pl.mem_read       = d_mem_read       & d_valid;
    d_pl.mem_write      = d_mem_write      & d_valid;
    d_pl.in_port_select = d_in_port_select & d_valid;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (mem_busy)                    state_nxt = state;
    else if (flush)                  state_nxt = ST_RUN;
    else if (state == ST_RUN && haz) state_nxt = ST_BUBBLE;
    else                             state_nxt = ST_RUN;
  end

  // Edge action and front-end stall
  always_comb begin
    act      = ACT_LOAD;
    stall_fd = 1'b0;
    if (mem_busy) begin
      act      = ACT_HOLD;
      stall_fd = 1'b1;
    end else if (flush) begin
      act = ACT_CLEAR;
    end else if (state == ST_RUN && haz) begin
      act      = ACT_BUBBLE;
      stall_fd = 1'b1;
    end
  end

  // Execute-side payload and bubble counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      case (act)
        ACT_HOLD:  ex_q <= ex_q;
        ACT_CLEAR: ex_q <= '0;
        ACT_BUBBLE: begin
          ex_q <= '0;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
        default:   ex_q <= d_pl;
      endcase
    end
  end

  assign e_valid          = ex_q.valid;
  assign e_rsrc           = ex_q.rsrc;
  assign e_rdest          = ex_q.rdest;
  assign e_read_data1     = ex_q.read_data1;
  assign e_read_data2     = ex_q.read_data2;
  assign e_imm            = ex_q.imm;
  assign e_alu_op         = ex_q.alu_op;
  assign e_reg_write      = ex_q.reg_write;
  assign e_mem_read       = ex_q.mem_read;
  assign e_mem_write      = ex_q.mem_write;
  assign e_in_port_select = ex_q.in_port_select;
  assign bubble_count     = cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register; a second instance with a 2-bit
// counter exercises saturation.
module tb_id_ex_pipeline_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid, d_uses_rsrc, d_uses_rdest;
  logic [3:0]  d_rsrc, d_rdest, d_alu_op;
  logic [15:0] d_read_data1, d_read_data2, d_imm;
  logic        d_reg_write, d_mem_read, d_mem_write, d_in_port_select;
  logic        mem_busy, flush;

  logic        e_valid, e_reg_write, e_mem_read, e_mem_write, e_in_port_select, stall_fd;
  logic [3:0]  e_rsrc, e_rdest, e_alu_op;
  logic [15:0] e_read_data1, e_read_data2, e_imm, bubble_count;

  logic        s_valid, s_reg_write, s_mem_read, s_mem_write, s_in_port_select, s_stall_fd;
  logic [3:0]  s_rsrc, s_rdest, s_alu_op;
  logic [15:0] s_read_data1, s_read_data2, s_imm;
  logic [1:0]  s_bubble_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_register dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rsrc(d_rsrc), .d_rdest(d_rdest),
    .d_uses_rsrc(d_uses_rsrc), .d_uses_rdest(d_uses_rdest),
    .d_read_data1(d_read_data1), .d_read_data2(d_read_data2), .d_imm(d_imm),
    .d_alu_op(d_alu_op), .d_reg_write(d_reg_write), .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write), .d_in_port_select(d_in_port_select),
    .mem_busy(mem_busy), .flush(flush),
    .e_valid(e_valid), .e_rsrc(e_rsrc), .e_rdest(e_rdest),
    .e_read_data1(e_read_data1), .e_read_data2(e_read_data2), .e_imm(e_imm),
    .e_alu_op(e_alu_op), .e_reg_write(e_reg_write), .e_mem_read(e_mem_read),
    .e_mem_write(e_mem_write), .e_in_port_select(e_in_port_select),
    .stall_fd(stall_fd), .bubble_count(bubble_count)
  );

  id_ex_pipeline_register #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rsrc(d_rsrc), .d_rdest(d_rdest),
    .d_uses_rsrc(d_uses_rsrc), .d_uses_rdest(d_uses_rdest),
    .d_read_data1(d_read_data1), .d_read_data2(d_read_data2), .d_imm(d_imm),
    .d_alu_op(d_alu_op), .d_reg_write(d_reg_write), .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write), .d_in_port_select(d_in_port_select),
    .mem_busy(mem_busy), .flush(flush),
    .e_valid(s_valid), .e_rsrc(s_rsrc), .e_rdest(s_rdest),
    .e_read_data1(s_read_data1), .e_read_data2(s_read_data2), .e_imm(s_imm),
    .e_alu_op(s_alu_op), .e_reg_write(s_reg_write), .e_mem_read(s_mem_read),
    .e_mem_write(s_mem_write), .e_in_port_select(s_in_port_select),
    .stall_fd(s_stall_fd), .bubble_count(s_bubble_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [3:0] rs, input logic [3:0] rd,
                           input logic urs, input logic urd, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] op,
                           input logic rw, input logic mr);
    d_valid = v; d_rsrc = rs; d_rdest = rd; d_uses_rsrc = urs; d_uses_rdest = urd;
    d_read_data1 = a; d_read_data2 = b; d_imm = 16'h0000; d_alu_op = op;
    d_reg_write = rw; d_mem_read = mr; d_mem_write = 1'b0; d_in_port_select = 1'b0;
  endtask

  // LDD R3 enters execute on the next edge
  task automatic load_r3();
    set_instr(1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b1);
    tick();
  endtask

  initial begin
    mem_busy = 1'b0; flush = 1'b0; rst_n = 1'b0;
    set_instr(1'b1, 4'd9, 4'd7, 1'b1, 1'b1, 16'hBEEF, 16'hCAFE, 4'd5, 1'b1, 1'b1);
    d_imm = 16'h1234; d_mem_write = 1'b1; d_in_port_select = 1'b1;
    tick(); tick();
    check("rst_e_valid", 32'(e_valid), 32'd0);
    check("rst_e_rdest", 32'(e_rdest), 32'd0);
    check("rst_e_data1", 32'(e_read_data1), 32'd0);
    check("rst_e_ctrl", {28'd0, e_reg_write, e_mem_read, e_mem_write, e_in_port_select}, 32'd0);
    check("rst_bubble_count", 32'(bubble_count), 32'd0);
    check("rst_stall_fd", 32'(stall_fd), 32'd0);

    rst_n = 1'b1;
    // Normal pass
    set_instr(1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 16'h0005, 16'h000A, 4'd3, 1'b1, 1'b0);
    #1 check("norm_stall", 32'(stall_fd), 32'd0);
    tick();
    check("norm_valid", 32'(e_valid), 32'd1);
    check("norm_regs", {24'd0, e_rsrc, e_rdest}, 32'h21);
    check("norm_data", {e_read_data1, e_read_data2}, 32'h0005_000A);
    check("norm_alu_op", 32'(e_alu_op), 32'd3);
    check("norm_ctrl", {28'd0, e_reg_write, e_mem_read, e_mem_write, e_in_port_select}, 32'h8);

    // Load-use through rsrc
    load_r3();
    check("ld_mem_read", 32'(e_mem_read), 32'd1);
    set_instr(1'b1, 4'd3, 4'd5, 1'b1, 1'b0, 16'h0011, 16'h0022, 4'd1, 1'b1, 1'b0);
    #1 check("lu_stall", 32'(stall_fd), 32'd1);
    tick();
    check("lu_bub_valid", 32'(e_valid), 32'd0);
    check("lu_bub_reg_write", 32'(e_reg_write), 32'd0);
    check("lu_bub_count", 32'(bubble_count), 32'd1);
    check("lu_bub_stall", 32'(stall_fd), 32'd0);
    tick();
    check("lu_held_valid", 32'(e_valid), 32'd1);
    check("lu_held_regs", {24'd0, e_rsrc, e_rdest}, 32'h35);
    check("lu_held_data2", 32'(e_read_data2), 32'h22);
    check("lu_held_stall", 32'(stall_fd), 32'd0);

    // No false hazard: operand use flags clear, then full-width mismatch
    load_r3();
    set_instr(1'b1, 4'd3, 4'd6, 1'b0, 1'b0, 16'h0001, 16'h0002, 4'd2, 1'b1, 1'b0);
    #1 check("nf_flags_stall", 32'(stall_fd), 32'd0);
    d_rsrc = 4'hB; d_uses_rsrc = 1'b1;
    #1 check("nf_width_stall", 32'(stall_fd), 32'd0);
    tick();
    check("nf_valid", 32'(e_valid), 32'd1);
    check("nf_rdest", 32'(e_rdest), 32'd6);
    check("nf_count", 32'(bubble_count), 32'd1);

    // Freeze for three cycles with a different decode instruction pending
    set_instr(1'b1, 4'd4, 4'd7, 1'b0, 1'b0, 16'h00AA, 16'h00BB, 4'd4, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("frz_stall", 32'(stall_fd), 32'd1);
      tick();
      check("frz_rdest", 32'(e_rdest), 32'd6);
      check("frz_data1", 32'(e_read_data1), 32'h1);
    end
    mem_busy = 1'b0;
    check("frz_count", 32'(bubble_count), 32'd1);

    // Flush together with a hazard
    load_r3();
    set_instr(1'b1, 4'd3, 4'd5, 1'b1, 1'b0, 16'h0011, 16'h0022, 4'd1, 1'b1, 1'b0);
    flush = 1'b1;
    #1 check("fl_stall", 32'(stall_fd), 32'd0);
    tick();
    flush = 1'b0;
    check("fl_valid", 32'(e_valid), 32'd0);
    check("fl_payload", {e_rdest, e_read_data2[11:0], e_alu_op, e_reg_write, e_mem_read, 10'd0}, 32'd0);
    check("fl_count", 32'(bubble_count), 32'd1);

    // Reset while in BUBBLE
    load_r3();
    set_instr(1'b1, 4'd3, 4'd5, 1'b1, 1'b0, 16'h0011, 16'h0022, 4'd1, 1'b1, 1'b0);
    tick();
    check("rb_count_pre", 32'(bubble_count), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rb_count", 32'(bubble_count), 32'd0);
    check("rb_valid", 32'(e_valid), 32'd0);
    #1 check("rb_stall", 32'(stall_fd), 32'd0);
    tick();
    check("rb_load_valid", 32'(e_valid), 32'd1);
    check("rb_load_rdest", 32'(e_rdest), 32'd5);
    check("rb_load_count", 32'(bubble_count), 32'd0);

    // Saturation: four hazards, alternating rsrc and rdest operand paths
    for (int i = 0; i < 4; i++) begin
      load_r3();
      if (i % 2 == 0)
        set_instr(1'b1, 4'd3, 4'd8, 1'b1, 1'b0, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0);
      else
        set_instr(1'b1, 4'd9, 4'd3, 1'b0, 1'b1, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0);
      #1 check("sat_stall", 32'(stall_fd), 32'd1);
      tick();
      check("sat_count", 32'(s_bubble_count), (i < 3) ? 32'(i + 1) : 32'd3);
      check("wide_count", 32'(bubble_count), 32'(i + 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
